// File: rtl/acc_sched_pkg.sv
// Shared definitions for the AXIS accumulator scheduler.
//   state_t  : scheduler FSM encoding (IDLE, XFER, FULL)
//   DEF_*    : default values for N, W and MAX_SUM
//   sum_w()  : width of the shadow total for a given beat width
package acc_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    FULL = 2'd2
  } state_t;

  localparam int DEF_N       = 2;
  localparam int DEF_W       = 3;
  localparam int DEF_MAX_SUM = 99;

  // Room for a full display value plus one extra beat without wrapping.
  function automatic int sum_w(input int w);
    return 2 * w + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req        : request vector, one bit per requester
//   last_owner : index of the most recent owner; search starts one above it
//   win        : one-hot winner (all zero when no request)
//   win_idx    : binary index of the winner
//   win_vld    : at least one request present
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_owner,
  output logic [N-1:0]  win,
  output logic [IW-1:0] win_idx,
  output logic          win_vld
);

  always_comb begin
    logic [IW-1:0] idx;
    win     = '0;
    win_idx = '0;
    win_vld = 1'b0;
    idx     = '0;
    // Walk last_owner+1 .. last_owner+N (mod N); first hit wins.
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(last_owner) + k) % N);
      if (!win_vld && req[idx]) begin
        win_vld  = 1'b1;
        win[idx] = 1'b1;
        win_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/axis_acc_sched.sv
// Round-robin scheduler sharing one count_sum accumulator between N AXIS
// requesters. A grant is held for a whole packet (until tlast); each accepted
// beat becomes an incr/acc_data strobe. A shadow total backpressures any beat
// that would push the display past MAX_SUM; software acknowledges the FULL
// condition with full_ack, which clears the accumulator via acc_clr.
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   s_tvalid/s_tready/s_tdata/s_tlast : per-requester AXIS slave inputs
//   grant      : one-hot current owner, zero when idle
//   incr, acc_data, acc_clr : registered strobes towards count_sum
//   total      : shadow sum since last clear
//   full       : high while waiting for full_ack
//   full_ack   : software acknowledge, ignored outside FULL
//   dbg_state  : current FSM state for observation
//
// Handshake: a beat transfers on a rising edge where s_tvalid[i] and
// s_tready[i] are both high; requesters keep tdata/tlast stable while
// valid is high and ready is low, and only the granted requester ever
// sees ready high.
module axis_acc_sched
  import acc_sched_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int W       = DEF_W,
  parameter int MAX_SUM = DEF_MAX_SUM,
  localparam int SW     = sum_w(W),
  localparam int IW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   s_tvalid,
  output logic [N-1:0]   s_tready,
  input  logic [N*W-1:0] s_tdata,
  input  logic [N-1:0]   s_tlast,
  output logic [N-1:0]   grant,
  output logic           incr,
  output logic [W-1:0]   acc_data,
  output logic           acc_clr,
  output logic [SW-1:0]  total,
  output logic           full,
  input  logic           full_ack,
  output state_t         dbg_state
);

  state_t        state;
  logic [IW-1:0] owner;
  logic [IW-1:0] last_owner;

  logic [N-1:0]  arb_win;
  logic [IW-1:0] arb_idx;
  logic          arb_vld;

  logic [W-1:0]  beat;
  logic          beat_valid;
  logic          beat_last;
  logic [SW:0]   sum_ext;
  logic          ovf;

  rr_arbiter #(.N(N), .IW(IW)) u_arb (
    .req        (s_tvalid),
    .last_owner (last_owner),
    .win        (arb_win),
    .win_idx    (arb_idx),
    .win_vld    (arb_vld)
  );

  assign beat       = s_tdata[int'(owner)*W +: W];
  assign beat_valid = s_tvalid[owner];
  assign beat_last  = s_tlast[owner];

  // One extra bit so the comparison never sees a wrapped sum.
  assign sum_ext = {1'b0, total} + (SW+1)'(beat);
  assign ovf     = sum_ext > (SW+1)'(MAX_SUM);

  always_comb begin
    s_tready = '0;
    if (state == XFER && !ovf) s_tready = grant;
  end

  assign full      = (state == FULL);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      owner      <= '0;
      last_owner <= IW'(N - 1);
      incr       <= 1'b0;
      acc_data   <= '0;
      acc_clr    <= 1'b0;
      total      <= '0;
    end else begin
      incr    <= 1'b0;
      acc_clr <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_vld) begin
            grant <= arb_win;
            owner <= arb_idx;
            state <= XFER;
          end
        end
        XFER: begin
          // No timeout: an idle owner keeps the grant until its tlast.
          if (beat_valid) begin
            if (!ovf) begin
              incr     <= 1'b1;
              acc_data <= beat;
              total    <= sum_ext[SW-1:0];
              if (beat_last) begin
                last_owner <= owner;
                grant      <= '0;
                state      <= IDLE;
              end
            end else begin
              state <= FULL;
            end
          end
        end
        FULL: begin
          // Owner is kept so the blocked beat is taken right after the clear.
          if (full_ack) begin
            acc_clr <= 1'b1;
            total   <= '0;
            state   <= XFER;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Requester-side protocol: a stalled beat must not change.
  logic hold;
  assign hold = (state != IDLE) && beat_valid && !s_tready[owner];

  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    hold |=> (beat_valid && $stable(beat) && $stable(beat_last)));

  a_strobe_excl: assert property (@(posedge clk) disable iff (rst)
    !(incr && acc_clr));

endmodule

// File: tb/tb_axis_acc_sched.sv
module tb_axis_acc_sched;
  import acc_sched_pkg::*;

  localparam int N  = 2;
  localparam int W  = 3;
  localparam int SW = 2 * W + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]   s_tvalid = '0;
  logic [N-1:0]   s_tready;
  logic [N*W-1:0] s_tdata  = '0;
  logic [N-1:0]   s_tlast  = '0;
  logic [N-1:0]   grant;
  logic           incr;
  logic [W-1:0]   acc_data;
  logic           acc_clr;
  logic [SW-1:0]  total;
  logic           full;
  logic           full_ack = 1'b0;
  state_t         dbg_state;

  axis_acc_sched #(.N(N), .W(W), .MAX_SUM(99)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .s_tdata   (s_tdata),
    .s_tlast   (s_tlast),
    .grant     (grant),
    .incr      (incr),
    .acc_data  (acc_data),
    .acc_clr   (acc_clr),
    .total     (total),
    .full      (full),
    .full_ack  (full_ack),
    .dbg_state (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  logic [W:0]   q0[$];        // {last, data} pending for requester 0
  logic [W:0]   q1[$];
  logic [W-1:0] exp_q[$];     // expected acc_data per incr
  logic [N-1:0] glog[$];      // sequence of new grants
  logic [N-1:0] pause = '0;
  logic [N-1:0] acc_hs = '0;
  logic [N-1:0] prev_grant = '0;
  int model_total = 0;
  int acc_cnt0 = 0, acc_cnt1 = 0, acc_all = 0;
  int incr_cnt = 0, clr_cnt = 0;
  int cur_pkt = -1;

  // Handshakes as seen by the DUT at the edge.
  always @(posedge clk) acc_hs <= rst ? '0 : (s_tvalid & s_tready);

  task automatic note_accept(input int r, input logic [W:0] b);
    exp_q.push_back(b[W-1:0]);
    model_total += int'(b[W-1:0]);
    acc_all++;
    if (r == 0) acc_cnt0++; else acc_cnt1++;
    if (cur_pkt >= 0) check("pkt_lock", r, cur_pkt);
    cur_pkt = b[W] ? -1 : r;
  endtask

  // ---------------- driver + monitor ----------------
  always @(negedge clk) begin
    logic [W:0] b;
    if (acc_hs[0]) begin
      if (q0.size() == 0) check("hs_empty0", 1, 0);
      else begin b = q0.pop_front(); note_accept(0, b); end
    end
    if (acc_hs[1]) begin
      if (q1.size() == 0) check("hs_empty1", 1, 0);
      else begin b = q1.pop_front(); note_accept(1, b); end
    end
    s_tvalid[0]     = !pause[0] && (q0.size() > 0);
    s_tdata[0 +: W] = (q0.size() > 0) ? q0[0][W-1:0] : '0;
    s_tlast[0]      = (q0.size() > 0) && q0[0][W];
    s_tvalid[1]     = !pause[1] && (q1.size() > 0);
    s_tdata[W +: W] = (q1.size() > 0) ? q1[0][W-1:0] : '0;
    s_tlast[1]      = (q1.size() > 0) && q1[0][W];

    if (!rst && incr) begin
      incr_cnt++;
      if (exp_q.size() == 0) check("incr_unexpected", 1, 0);
      else check("acc_data", acc_data, exp_q.pop_front());
      check("incr_clr_excl", acc_clr, 0);
    end
    if (!rst && acc_clr) clr_cnt++;
    if (grant != prev_grant && grant != '0) glog.push_back(grant);
    prev_grant = grant;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_beat(input int r, input int data, input bit last);
    logic [W:0] b;
    b = {last, W'(data)};
    if (r == 0) q0.push_back(b); else q1.push_back(b);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || grant != '0) && n < budget) begin
      tick(); n++;
    end
    check(tag, q0.size() + q1.size() + int'(grant != '0), 0);
  endtask

  task automatic wait_q0_empty(input int budget, input string tag);
    int n = 0;
    while (q0.size() != 0 && n < budget) begin tick(); n++; end
    check(tag, q0.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    check("rst_grant", grant, 0);
    check("rst_tready", s_tready, 0);
    check("rst_incr", incr, 0);
    check("rst_acc_data", acc_data, 0);
    check("rst_acc_clr", acc_clr, 0);
    check("rst_total", total, 0);
    check("rst_full", full, 0);
    rst = 1'b0;
    tick();

    // Single packet 3,5,7 from requester 0.
    push_beat(0, 3, 0); push_beat(0, 5, 0); push_beat(0, 7, 1);
    tick();
    tick();
    check("t1_grant", grant, 2'b01);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t1_incr", incr, 1);
    end
    check("t1_grant_idle", grant, 0);
    check("t1_total", total, 15);

    // Both requesters, 2-beat packets; last_owner is 0 so requester 1 starts.
    glog.delete();
    push_beat(0, 1, 0); push_beat(0, 2, 1); push_beat(0, 3, 0); push_beat(0, 4, 1);
    push_beat(1, 5, 0); push_beat(1, 6, 1); push_beat(1, 7, 0); push_beat(1, 1, 1);
    wait_idle(100, "t2_timeout");
    check("t2_glog_size", glog.size(), 4);
    if (glog.size() == 4) begin
      check("t2_g0", glog[0], 2'b10);
      check("t2_g1", glog[1], 2'b01);
      check("t2_g2", glog[2], 2'b10);
      check("t2_g3", glog[3], 2'b01);
    end
    check("t2_total", total, 44);
    check("t2_total_model", total, model_total);

    // Reset mid-packet of requester 1 after two beats.
    acc_cnt1 = 0;
    push_beat(1, 2, 0); push_beat(1, 3, 0); push_beat(1, 4, 1);
    push_beat(0, 6, 1);
    for (int n = 0; n < 20 && acc_cnt1 < 2; n++) tick();
    check("t3_two_beats", acc_cnt1, 2);
    rst = 1'b1;
    tick();
    q0.delete(); q1.delete();
    model_total = 0; cur_pkt = -1;
    check("t3_grant", grant, 0);
    check("t3_tready", s_tready, 0);
    check("t3_incr", incr, 0);
    check("t3_acc_data", acc_data, 0);
    check("t3_acc_clr", acc_clr, 0);
    check("t3_total", total, 0);
    check("t3_full", full, 0);
    tick();
    glog.delete();
    push_beat(0, 7, 0); push_beat(0, 7, 0); push_beat(0, 7, 0);
    push_beat(0, 7, 0); push_beat(0, 7, 0); push_beat(0, 5, 0);
    push_beat(1, 1, 1);
    rst = 1'b0;
    wait_q0_empty(40, "t3_timeout");
    check("t3_first_grant", (glog.size() > 0) ? glog[0] : 2'b00, 2'b01);
    check("t4_total40", total, 40);

    // full_ack in XFER is ignored; owner idle keeps the grant.
    pause[0] = 1'b1;
    full_ack = 1'b1;
    tick();
    full_ack = 1'b0;
    check("t4_no_clr", acc_clr, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t6_grant_hold", grant, 2'b01);
      check("t6_no_incr", incr, 0);
    end
    check("t4_total_kept", total, 40);

    // Resume to 97, then offer 5 -> FULL.
    for (int i = 0; i < 8; i++) push_beat(0, 7, 0);
    push_beat(0, 1, 0);
    push_beat(0, 5, 1);
    pause[0] = 1'b0;
    for (int n = 0; n < 40 && full !== 1'b1; n++) tick();
    check("t5_full", full, 1);
    check("t5_total97", total, 97);
    check("t5_model97", model_total, 97);
    check("t5_tready", s_tready, 0);
    tick();
    check("t5_still_full", full, 1);
    check("t5_no_incr", incr, 0);
    check("t5_tready2", s_tready, 0);
    full_ack = 1'b1;
    tick();
    full_ack = 1'b0;
    model_total = 0;
    check("t5_clr", acc_clr, 1);
    check("t5_total0", total, 0);
    check("t5_full_off", full, 0);
    tick();
    check("t5_incr", incr, 1);
    check("t5_total5", total, 5);
    check("t5_clr_once", acc_clr, 0);
    check("t5_grant_idle", grant, 0);

    wait_idle(40, "t6_timeout");
    check("end_total", total, 6);
    check("end_total_model", total, model_total);
    check("end_clr_cnt", clr_cnt, 1);
    check("end_incr_cnt", incr_cnt, acc_all);
    check("end_exp_q", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axis_acc_sched.md
Name: axis_acc_sched

Overview:
- Round-robin scheduler that shares the single count_sum accumulator between N AXI-Stream requesters.
- Holds a grant for a whole packet (until tlast) and converts accepted beats into incr/data strobes for the accumulator.
- Keeps a shadow total and backpressures any beat that would push the two-digit display past MAX_SUM.
- Sits between the AXIS input ports and count_sum. Drives a clear strobe for the accumulator once software acknowledges a full condition.

Parameters:
- N, 2, number of AXIS requesters (2..8).
- W, 3, tdata width per requester; matches count_sum w.
- MAX_SUM, 99, largest total the two-digit display can show.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- s_tvalid  in  N  per-requester beat valid.
- s_tready  out  N  per-requester ready; at most one bit high.
- s_tdata  in  N*W  requester i data at bits [i*W +: W].
- s_tlast  in  N  per-requester last beat of packet.
- grant  out  N  one-hot current owner; all-zero when idle.
- incr  out  1  one-cycle strobe to count_sum.incr.
- acc_data  out  W  beat value to count_sum.s_data; valid while incr=1.
- acc_clr  out  1  one-cycle strobe to clear the accumulator.
- total  out  2W+1  shadow sum of all beats accepted since the last clear.
- full  out  1  high while in FULL state.
- full_ack  in  1  software acknowledge of full.

Behaviour:
- Reset: clk and rst only, synchronous, active-high. While rst=1 at a clock edge:
  - state=IDLE; grant=0; s_tready=0; incr=0; acc_data=0; acc_clr=0; total=0; full=0.
  - last_owner=N-1, so requester 0 wins first.
  - Reset mid-packet abandons the packet. No partial state survives.
- States: IDLE, XFER, FULL (enum in package).
- IDLE:
  - s_tready=0.
  - If any s_tvalid, pick the first set bit searching from last_owner+1 modulo N.
  - Register the winner into grant and go to XFER next cycle (1-cycle arbitration latency).
- XFER (owner g):
  - ovf = total + s_tdata[g] > MAX_SUM, evaluated at full width 2W+1; no wrap.
  - s_tready[g] = !ovf (combinational from registered total and the input). Other ready bits are 0.
  - Handshake (s_tvalid[g] & s_tready[g]):
    - next cycle incr=1, acc_data=beat, total=total+beat.
    - Back-to-back beats are accepted every cycle.
  - Handshake with s_tlast[g]: last_owner=g, grant=0, go to IDLE.
  - s_tvalid[g]=1 and ovf=1: no accept; go to FULL; full=1 next cycle.
  - s_tvalid[g]=0: stay in XFER holding the grant. No timeout; packet lock is absolute.
- FULL:
  - All tready=0; grant stays on g.
  - On full_ack: acc_clr=1 for exactly one cycle, total=0, full=0, return to XFER with the same owner. The blocked beat is then accepted normally.
  - A beat value greater than MAX_SUM, with total=0, re-enters FULL. This is legal and stalls until the next ack. Only reachable if MAX_SUM < 2^W-1.
- full_ack outside FULL is ignored.
- incr, acc_data and acc_clr are registered outputs. incr and acc_clr are never high in the same cycle.
- Zero-valued beats are accepted and pulse incr; total is unchanged.
- Requester-side AXIS rules (tdata/tlast stable while valid & !ready) are assumed by protocol and checked by assertions only.

Decomposition:
- Package acc_sched_pkg:
  - state_t enum {IDLE, XFER, FULL}.
  - Default constants for N, W, MAX_SUM.
  - Function sum_w(W)=2W+1.
- Sub-module rr_arbiter (N): inputs req[N] and last_owner; outputs a one-hot winner and its index. Purely combinational.
- All other logic lives in axis_acc_sched.

Test Plan:
- Single requester 0 sends a packet of 3,5,7 (tlast on 7) back-to-back:
  - grant=01 one cycle after tvalid;
  - incr high for 3 consecutive cycles with acc_data 3,5,7;
  - total=15; grant=00 after the last beat.
- Both requesters hold valid continuously with 2-beat packets:
  - grants alternate 0,1,0,1;
  - requester 1 never starts mid-packet of requester 0;
  - total is the sum of all accepted beats.
- Overflow: total=97, owner offers 5:
  - s_tready low, full=1, no incr;
  - pulse full_ack: acc_clr pulses once, total=0, then beat 5 is accepted (total=5, incr with acc_data=5).
- full_ack pulsed while in XFER with total=40: no acc_clr; total stays 40.
- rst asserted mid-packet after 2 beats:
  - next cycle all outputs 0, total=0;
  - after release, requester 0 wins despite requester 1 also being valid.
- Owner drops tvalid for 4 cycles mid-packet while requester 1 is valid: grant stays on 0 and no incr occurs; the packet resumes normally.
